booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
Parametrised, iterative radix-4 Booth multiplier for the datapath MUL instruction. It retires one Booth digit per clock and supports both signed and unsigned operands. It returns the exact double-width product for the HI/LO registers. Control starts it with a start/busy/done handshake and stalls the CPU until done.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4
STEPS, WIDTH/2+1, derived (localparam), number of radix-4 iterations

Ports:
clock  input  1  rising-edge clock
clear  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
m  input  WIDTH  multiplicand; sampled with start
q  input  WIDTH  multiplier; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, product valid
product  output  2*WIDTH  result; held until the next accepted start completes

Behaviour:
- Reset (clear=0, async): state=IDLE; busy=0, done=0, product=0; all internal registers zeroed. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: on edge with start=1, latch operands and go to RUN with cnt=0.
  - RUN: one Booth step per edge. At the edge where cnt==STEPS-1, write product and go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Operand latch:
  - Mx = m extended to WIDTH+2 bits (sign-extended if is_signed, else zero-extended).
  - Qx = q extended the same way, with an appended q[-1]=0.
  - Accumulator A = 0, width WIDTH+4.
- Step:
  - Digit from {Qx[1],Qx[0],q[-1]}: 000/111 -> 0, 001/010 -> +Mx, 011 -> +2Mx, 100 -> -2Mx, 101/110 -> -Mx.
  - Negation is ~x+1 at full A width.
  - A <= A + digit. Then the combined {A,Qx,q[-1]} shifts arithmetically right by 2.
- Result: product = low 2*WIDTH bits of {A,Qx} after STEPS steps. It must equal the exact mathematical product: signed×signed or unsigned×unsigned per the latched is_signed.
- Latency: start accepted at edge E0; done is high in the cycle after edge E(STEPS); busy is high from E0 through E(STEPS+1). For WIDTH=32, done appears 17 cycles after the accept edge.
- start while busy (RUN or DONE) is ignored. Input changes after the accept edge do not affect the operation. A new start is accepted only in IDLE, so the minimum issue interval is STEPS+2 cycles.
- product changes only at the final RUN edge or on reset; it is never partially updated.

Decomposition:
- Shared package mul_pkg holds:
  - state enum {IDLE, RUN, DONE}, 2-bit;
  - Booth digit encoding constants (ZERO, P1, P2, N1, N2);
  - function for the 3-bit to digit map.
- One natural sub-module: booth_r4_encode. It is combinational: 3-bit group in, {zero, neg, two} out. Each step instantiates it once.

Test Plan:
1. WIDTH=32, unsigned, m=q=0xFFFFFFFF -> product=0xFFFFFFFE00000001; done exactly 17 cycles after the accept edge; busy drops one cycle later.
2. WIDTH=32, signed, m=q=0xFFFFFFFF (-1×-1) -> product=0x0000000000000001.
3. WIDTH=32, signed:
   - 0x80000000×0x80000000 -> 0x4000000000000000;
   - 0x80000000×0x00000001 -> 0xFFFFFFFF80000000;
   - 7×0xFFFFFFFD -> 0xFFFFFFFFFFFFFFEB.
4. WIDTH=32, start 5×6 unsigned. Then:
   - pulse start with 9×9 at cycles 3 and during DONE -> ignored, product=0x1E, a single done pulse;
   - changing m/q mid-RUN has no effect.
5. Pull clear low mid-RUN at cycle 8 -> busy=0, done=0, product=0 immediately; no done pulse follows. A subsequent start 3×4 -> product=0xC.
6. WIDTH=8 instance:
   - unsigned 200×200 -> 0x9C40 after 5 cycles;
   - signed 0x80×0x80 -> 0x4000;
   - signed 0x7F×0x81 -> 0xC0FF.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and the radix-4 Booth digit map used by the sequential multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth digit values: zero, +1, +2, -1, -2 times the multiplicand
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        N1   = 3'd3,
        N2   = 3'd4
    } digit_t;

    // Map the 3-bit group {q[i+1], q[i], q[i-1]} to its Booth digit
    function automatic digit_t booth_digit(input logic [2:0] grp);
        digit_t d;
        case (grp)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = N2;
            3'b101, 3'b110: d = N1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Request/response bundle between the control unit and the Booth multiplier.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     q;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, m, q,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, m, q,
        output busy, done, product
    );
endinterface

// File: rtl/booth_r4_encode.sv
// Radix-4 Booth recoder: one 3-bit multiplier group to {zero, neg, two} controls.
module booth_r4_encode
    import mul_pkg::*;
(
    input  logic [2:0] grp,
    output logic       zero,
    output logic       neg,
    output logic       two
);
    digit_t dig;

    // Decode the group through the shared digit map into adder controls
    always_comb begin
        dig  = booth_digit(grp);
        zero = (dig == ZERO);
        neg  = (dig == N1) || (dig == N2);
        two  = (dig == P2) || (dig == N2);
    end
endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed or unsigned.
// Operands are widened by two bits so both signednesses run through the same
// signed datapath; the accumulator gets two more bits of headroom for +/-2M.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           clear,
    booth_mul_seq_if.slave bus
);
    localparam int STEPS = WIDTH / 2 + 1;
    localparam int XW    = WIDTH + 2;
    localparam int AW    = WIDTH + 4;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t state, state_next;

    logic signed [XW-1:0] mx;
    logic signed [XW-1:0] qx;
    logic                 qm1;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   product_r;

    logic                 zero, neg, two;
    logic signed [AW-1:0] mx_ext, addend, sum, acc_next;
    logic signed [XW-1:0] qx_next;
    logic                 last;

    function automatic logic signed [XW-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
        return {{2{s & v[WIDTH-1]}}, v};
    endfunction

    booth_r4_encode u_enc (
        .grp  ({qx[1:0], qm1}),
        .zero (zero),
        .neg  (neg),
        .two  (two)
    );

    // One Booth step: add the selected multiple, then shift {A,Qx,q-1} right by two
    always_comb begin
        mx_ext = {{2{mx[XW-1]}}, mx};
        addend = two ? (mx_ext <<< 1) : mx_ext;
        if (neg)
            addend = ~addend + AW'(1);
        if (zero)
            addend = '0;
        sum      = acc + addend;
        acc_next = sum >>> 2;
        qx_next  = {sum[1:0], qx[XW-1:2]};
        last     = (cnt == CW'(STEPS - 1));
    end

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_next = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last)
                    state_next = DONE;
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration and single-shot product write on the last step
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mx        <= '0;
            qx        <= '0;
            qm1       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mx  <= extend(bus.m, bus.is_signed);
                        qx  <= extend(bus.q, bus.is_signed);
                        qm1 <= 1'b0;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    qx  <= qx_next;
                    qm1 <= qx[1];
                    cnt <= cnt + CW'(1);
                    if (last)
                        product_r <= {acc_next[WIDTH-3:0], qx_next};
                end
                default: ;
            endcase
        end
    end

    assign bus.product = product_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomized self-checking bench for booth_mul_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mul_seq;
    logic clock;
    logic clear;

    booth_mul_seq_if #(.WIDTH(32)) bus32 ();
    booth_mul_seq_if #(.WIDTH(8))  bus8 ();

    booth_mul_seq #(.WIDTH(32)) dut32 (.clock(clock), .clear(clear), .bus(bus32));
    booth_mul_seq #(.WIDTH(8))  dut8  (.clock(clock), .clear(clear), .bus(bus8));

    int n_tests = 0;
    int n_fail  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact product of two w-bit operands, truncated to 2w bits
    function automatic logic [63:0] ref_mul(input int w, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ea, eb, r;
        mask = (64'd1 << w) - 64'd1;
        ea = {32'd0, a} & mask;
        eb = {32'd0, b} & mask;
        if (s && ea[w-1]) ea = ea | ~mask;
        if (s && eb[w-1]) eb = eb | ~mask;
        r = ea * eb;
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
        int cyc;
        @(negedge clock);
        bus32.start = 1'b1; bus32.is_signed = s; bus32.m = a; bus32.q = b;
        @(posedge clock); #1;
        bus32.start = 1'b0;
        cyc = 0;
        while (!bus32.done && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd17);
        check({tag, "_prod"}, bus32.product, exp);
        @(posedge clock); #1;
        check({tag, "_busy_drop"}, 64'({bus32.busy, bus32.done}), 64'd0);
    endtask

    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [63:0] exp, input string tag);
        int cyc;
        @(negedge clock);
        bus8.start = 1'b1; bus8.is_signed = s; bus8.m = a; bus8.q = b;
        @(posedge clock); #1;
        bus8.start = 1'b0;
        cyc = 0;
        while (!bus8.done && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd5);
        check({tag, "_prod"}, 64'(bus8.product), exp);
        @(posedge clock); #1;
        check({tag, "_busy_drop"}, 64'({bus8.busy, bus8.done}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        logic s;
        logic [31:0] a, b;

        clear = 1'b0;
        bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.m = '0; bus32.q = '0;
        bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.m  = '0; bus8.q  = '0;
        #1;
        check("reset32", {bus32.product[61:0], bus32.busy, bus32.done}, 64'd0);
        check("reset8", 64'({bus8.product, bus8.busy, bus8.done}), 64'd0);
        repeat (3) @(negedge clock);
        clear = 1'b1;

        // Directed WIDTH=32 cases
        op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "u_max");
        op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "s_m1m1");
        op32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "s_minmin");
        op32(1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, "s_min1");
        op32(1'b1, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "s_7m3");

        // Ignored starts and operand changes while busy
        @(negedge clock);
        bus32.start = 1'b1; bus32.is_signed = 1'b0; bus32.m = 32'd5; bus32.q = 32'd6;
        @(posedge clock); #1;
        bus32.start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clock); #1;
            if (bus32.done) ndone++;
            if (i == 3) begin bus32.start = 1'b1; bus32.m = 32'd9; bus32.q = 32'd9; end
            if (i == 4) bus32.start = 1'b0;
            if (i == 6) begin bus32.m = $urandom; bus32.q = $urandom; bus32.is_signed = 1'b1; end
        end
        check("busy_ign_done_at17", 64'(bus32.done), 64'd1);
        bus32.start = 1'b1; bus32.m = 32'd9; bus32.q = 32'd9; bus32.is_signed = 1'b0;
        @(posedge clock); #1;
        bus32.start = 1'b0;
        check("busy_ign_prod", bus32.product, 64'h1E);
        for (int i = 0; i < 22; i++) begin
            @(posedge clock); #1;
            if (bus32.done) ndone++;
        end
        check("busy_ign_single_done", 64'(ndone), 64'd1);
        check("busy_ign_prod_held", bus32.product, 64'h1E);

        // Asynchronous reset mid-operation
        @(negedge clock);
        bus32.start = 1'b1; bus32.is_signed = 1'b0; bus32.m = 32'd1234; bus32.q = 32'd5678;
        @(posedge clock); #1;
        bus32.start = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("abort_outputs", {bus32.product[61:0], bus32.busy, bus32.done}, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock); #1;
            if (bus32.done || bus32.busy) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        op32(1'b0, 32'd3, 32'd4, 64'hC, "after_abort");

        // Directed WIDTH=8 cases
        op8(1'b0, 8'd200, 8'd200, 64'h9C40, "w8_u200");
        op8(1'b1, 8'h80,  8'h80,  64'h4000, "w8_minmin");
        op8(1'b1, 8'h7F,  8'h81,  64'hC0FF, "w8_7f81");

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a = 32'h8000_0000;
            if (i % 7 == 0) b = 32'h7FFF_FFFF;
            op32(s, a, b, ref_mul(32, s, a, b), "rand32");
        end
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom);
            a = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(0, 255));
            op8(s, a[7:0], b[7:0], ref_mul(8, s, a, b), "rand8");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
